// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, line FSM states and frame-length helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } uart_state_e;

    function automatic int frame_len(input int clk_div, input int data_bits,
                                     input int parity, input int stop_bits);
        return clk_div * (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered occupancy; overflow/underflow requests are dropped.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW + 1)'(1);
                2'b01:   level <= level - (AW + 1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-fronted UART transmitter; pops the next word on the last stop cycle so frames abut.
// state | meaning: IDLE line high | START start bit | DATA data LSB first | PAR parity | STOP stop bit(s)
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 25,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    input  logic [DATA_BITS-1:0]        tx_data,
    output logic                        uart_txd,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int BIT_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int BIT_W   = $clog2(BIT_MAX);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    uart_state_e          state, state_next;
    logic [DIV_W-1:0]     div_cnt, div_next;
    logic [BIT_W-1:0]     bit_cnt, bit_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic                 par_bit, par_next;
    logic                 txd_next;
    logic                 tick;
    logic                 load;
    logic                 push;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;

    assign push     = tx_valid && tx_ready;
    assign tx_ready = !fifo_full;
    assign tx_busy  = (state != ST_IDLE) || !fifo_empty;
    assign tick     = (div_cnt == DIV_LAST);

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .push  (push),
        .pop   (load),
        .wdata (tx_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        state_next = state;
        div_next   = '0;
        bit_next   = bit_cnt;
        shreg_next = shreg;
        par_next   = par_bit;
        txd_next   = uart_txd;
        load       = 1'b0;

        if (state != ST_IDLE && !tick) begin
            div_next = div_cnt + DIV_W'(1);
        end

        case (state)
            ST_IDLE: begin
                load = !fifo_empty;
            end
            ST_START: begin
                if (tick) begin
                    state_next = ST_DATA;
                    txd_next   = shreg[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_next = '0;
                        if (PARITY != PAR_NONE) begin
                            state_next = ST_PAR;
                            txd_next   = par_bit;
                        end else begin
                            state_next = ST_STOP;
                            txd_next   = 1'b1;
                        end
                    end else begin
                        bit_next   = bit_cnt + BIT_W'(1);
                        shreg_next = shreg >> 1;
                        txd_next   = shreg[1];
                    end
                end
            end
            ST_PAR: begin
                if (tick) begin
                    state_next = ST_STOP;
                    txd_next   = 1'b1;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (bit_cnt == STOP_LAST) begin
                        if (fifo_empty) begin
                            state_next = ST_IDLE;
                            txd_next   = 1'b1;
                            bit_next   = '0;
                        end else begin
                            load = 1'b1;
                        end
                    end else begin
                        bit_next = bit_cnt + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                txd_next   = 1'b1;
            end
        endcase

        // Parity is captured with the word so the shift register can be consumed freely.
        if (load) begin
            state_next = ST_START;
            txd_next   = 1'b0;
            bit_next   = '0;
            shreg_next = fifo_rdata;
            par_next   = (PARITY == PAR_ODD) ? ~^fifo_rdata : ^fifo_rdata;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state    <= ST_IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            uart_txd <= 1'b1;
        end else begin
            state    <= state_next;
            div_cnt  <= div_next;
            bit_cnt  <= bit_next;
            shreg    <= shreg_next;
            par_bit  <= par_next;
            uart_txd <= txd_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three configurations checked every cycle against a queue-based line model.
module tb_uart_tx_fifo;

    localparam int CLK_DIV = 25;
    localparam int DEPTH   = 4;
    localparam int NDUT    = 3;
    localparam int DB [NDUT] = '{8, 7, 8};
    localparam int PB [NDUT] = '{0, 2, 1};
    localparam int SB [NDUT] = '{1, 2, 1};

    logic            sys_clk = 1'b0;
    logic            sys_rst_n;
    logic [NDUT-1:0] tx_valid;
    logic [8:0]      tx_data [NDUT];
    logic [NDUT-1:0] tx_ready;
    logic [NDUT-1:0] uart_txd;
    logic [NDUT-1:0] tx_busy;
    logic [2:0]      fifo_level [NDUT];

    always #5 sys_clk = ~sys_clk;

    uart_tx_fifo #(.CLK_DIV(25), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
        .tx_data(tx_data[0][7:0]), .uart_txd(uart_txd[0]), .tx_busy(tx_busy[0]), .fifo_level(fifo_level[0]));

    uart_tx_fifo #(.CLK_DIV(25), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
        .tx_data(tx_data[1][6:0]), .uart_txd(uart_txd[1]), .tx_busy(tx_busy[1]), .fifo_level(fifo_level[1]));

    uart_tx_fifo #(.CLK_DIV(25), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut2 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
        .tx_data(tx_data[2][7:0]), .uart_txd(uart_txd[2]), .tx_busy(tx_busy[2]), .fifo_level(fifo_level[2]));

    int n_cmp;
    int n_bad;
    int cyc;

    // Reference: pending words and the exact per-cycle line levels still to be driven.
    bit         line_q [NDUT][$];
    logic [8:0] word_q [NDUT][$];

    typedef struct {
        int         dut;
        logic [8:0] data;
        int         nbits;
        logic [11:0] bits;
    } vec_t;

    vec_t vt [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void append_frame(input int i, input logic [8:0] w);
        int ones;
        bit pbit;
        ones = $countones(w);
        pbit = (PB[i] == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
        for (int c = 0; c < CLK_DIV; c++) line_q[i].push_back(1'b0);
        for (int b = 0; b < DB[i]; b++)
            for (int c = 0; c < CLK_DIV; c++) line_q[i].push_back(w[b]);
        if (PB[i] != 0)
            for (int c = 0; c < CLK_DIV; c++) line_q[i].push_back(pbit);
        for (int c = 0; c < SB[i] * CLK_DIV; c++) line_q[i].push_back(1'b1);
    endfunction

    function automatic void model_step();
        for (int i = 0; i < NDUT; i++) begin
            bit         push;
            bit         pop;
            logic [8:0] w;
            logic [8:0] mask;
            mask = 9'((1 << DB[i]) - 1);
            if (!sys_rst_n) begin
                line_q[i].delete();
                word_q[i].delete();
            end else begin
                push = tx_valid[i] && (word_q[i].size() < DEPTH);
                pop  = (word_q[i].size() > 0) && (line_q[i].size() <= 1);
                if (line_q[i].size() > 0) void'(line_q[i].pop_front());
                if (pop) begin
                    w = word_q[i].pop_front();
                    append_frame(i, w);
                end
                if (push) word_q[i].push_back(tx_data[i] & mask);
            end
        end
    endfunction

    task automatic cycle();
        @(posedge sys_clk);
        model_step();
        @(negedge sys_clk);
        cyc++;
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("txd%0d", i), 32'(uart_txd[i]),
                  32'((line_q[i].size() > 0) ? line_q[i][0] : 1'b1));
            check($sformatf("ready%0d", i), 32'(tx_ready[i]), 32'(word_q[i].size() < DEPTH));
            check($sformatf("busy%0d", i), 32'(tx_busy[i]),
                  32'((line_q[i].size() > 0) || (word_q[i].size() > 0)));
            check($sformatf("level%0d", i), 32'(fifo_level[i]), 32'(word_q[i].size()));
        end
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) cycle();
    endtask

    initial begin
        int         d;
        int         t0;
        int         acc;
        int         lowcnt;
        logic [7:0] got;
        logic [8:0] words [3];

        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        sys_rst_n = 1'b0;
        tx_valid  = '0;
        for (int i = 0; i < NDUT; i++) tx_data[i] = '0;

        vt[0] = '{dut: 0, data: 9'h055, nbits: 10, bits: 12'b0010_1010_1010};
        vt[1] = '{dut: 0, data: 9'h0A1, nbits: 10, bits: 12'b0011_0100_0010};
        vt[2] = '{dut: 1, data: 9'h007, nbits: 11, bits: 12'b0111_0000_1110};
        vt[3] = '{dut: 1, data: 9'h02A, nbits: 11, bits: 12'b0111_0101_0100};
        vt[4] = '{dut: 2, data: 9'h000, nbits: 11, bits: 12'b0110_0000_0000};
        vt[5] = '{dut: 2, data: 9'h0FF, nbits: 11, bits: 12'b0111_1111_1110};

        repeat (3) cycle();
        for (int i = 0; i < NDUT; i++) begin
            check("reset_txd", 32'(uart_txd[i]), 32'd1);
            check("reset_ready", 32'(tx_ready[i]), 32'd1);
            check("reset_busy", 32'(tx_busy[i]), 32'd0);
            check("reset_level", 32'(fifo_level[i]), 32'd0);
        end
        sys_rst_n = 1'b1;
        repeat (3) cycle();

        // Single frames with hand-derived bit patterns, sampled mid-bit.
        foreach (vt[v]) begin
            d = vt[v].dut;
            tx_valid[d] = 1'b1;
            tx_data[d]  = vt[v].data;
            cycle();
            tx_valid[d] = 1'b0;
            check("pre_fall_txd", 32'(uart_txd[d]), 32'd1);
            check("accept_busy", 32'(tx_busy[d]), 32'd1);
            cycle();
            check("fall_txd", 32'(uart_txd[d]), 32'd0);
            for (int b = 0; b < vt[v].nbits; b++) begin
                repeat (12) cycle();
                check($sformatf("vec%0d_bit%0d", v, b), 32'(uart_txd[d]), 32'(vt[v].bits[b]));
                if (b < vt[v].nbits - 1) begin
                    repeat (13) cycle();
                end else begin
                    repeat (12) cycle();
                    check("last_cycle_busy", 32'(tx_busy[d]), 32'd1);
                    cycle();
                    check("end_busy", 32'(tx_busy[d]), 32'd0);
                    check("end_txd", 32'(uart_txd[d]), 32'd1);
                end
            end
            repeat (5) cycle();
        end

        // Three words on consecutive cycles must come out as contiguous frames.
        words[0] = 9'h0A1;
        words[1] = 9'h0B2;
        words[2] = 9'h0C3;
        t0 = 0;
        for (int k = 0; k < 3; k++) begin
            tx_valid[0] = 1'b1;
            tx_data[0]  = words[k];
            cycle();
            if (k == 1) begin
                t0 = cyc;
                check("b2b_fall", 32'(uart_txd[0]), 32'd0);
            end
        end
        tx_valid[0] = 1'b0;
        for (int f = 0; f < 3; f++) begin
            if (f > 0) begin
                wait_to(t0 + 250 * f - 1);
                check($sformatf("b2b_stop%0d", f), 32'(uart_txd[0]), 32'd1);
                wait_to(t0 + 250 * f);
                check($sformatf("b2b_start%0d", f), 32'(uart_txd[0]), 32'd0);
            end
            got = '0;
            for (int j = 1; j <= 8; j++) begin
                wait_to(t0 + 250 * f + 25 * j + 12);
                got[j-1] = uart_txd[0];
            end
            check($sformatf("b2b_word%0d", f), 32'(got), 32'(words[f][7:0]));
        end
        while (tx_busy[0] && cyc < t0 + 2000) cycle();
        check("b2b_len", 32'(cyc - t0), 32'd750);
        repeat (5) cycle();

        // Continuous valid from idle: one word in flight plus a full FIFO.
        acc = 0;
        t0  = cyc;
        tx_valid[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tx_data[0] = 9'($urandom);
            if (tx_ready[0]) acc++;
            cycle();
        end
        tx_valid[0] = 1'b0;
        check("full_accepts", 32'(acc), 32'd5);
        check("full_level", 32'(fifo_level[0]), 32'd4);
        check("full_ready", 32'(tx_ready[0]), 32'd0);
        wait_to(t0 + 251);
        check("full_ready_before_pop", 32'(tx_ready[0]), 32'd0);
        cycle();
        check("full_ready_after_pop", 32'(tx_ready[0]), 32'd1);
        check("full_level_after_pop", 32'(fifo_level[0]), 32'd3);
        t0 = cyc;
        while (tx_busy[0] && cyc < t0 + 2000) cycle();
        check("full_drain", 32'(tx_busy[0]), 32'd0);
        repeat (5) cycle();

        // Reset mid-DATA with three words queued.
        for (int k = 0; k < 4; k++) begin
            tx_valid[0] = 1'b1;
            tx_data[0]  = 9'(k * 37 + 5);
            cycle();
        end
        tx_valid[0] = 1'b0;
        repeat (100) cycle();
        check("rst_queued", 32'(fifo_level[0]), 32'd3);
        sys_rst_n = 1'b0;
        cycle();
        sys_rst_n = 1'b1;
        check("rst_txd", 32'(uart_txd[0]), 32'd1);
        check("rst_level", 32'(fifo_level[0]), 32'd0);
        check("rst_busy", 32'(tx_busy[0]), 32'd0);
        check("rst_ready", 32'(tx_ready[0]), 32'd1);
        lowcnt = 0;
        for (int k = 0; k < 300; k++) begin
            cycle();
            if (!uart_txd[0]) lowcnt++;
        end
        check("rst_no_restart", 32'(lowcnt), 32'd0);

        // Random traffic on all three configurations.
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < NDUT; i++) begin
                tx_valid[i] = ($urandom_range(0, 3) == 0);
                tx_data[i]  = 9'($urandom);
            end
            cycle();
        end
        tx_valid = '0;
        t0 = cyc;
        while ((tx_busy != '0) && cyc < t0 + 3000) cycle();
        check("random_drain", 32'(tx_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
